// File: rtl/lu_serial.sv
// lu_serial: slice-serial eight-function bitwise logic unit with start/done handshake.
module lu_serial #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, res_q, res_d, p_next;
    logic             zero_q, zero_d;
    logic [SLICE-1:0] sa, sb, s;
    always_comb begin
        sa = a_q[SLICE-1:0];
        sb = b_q[SLICE-1:0];
        s  = op_q == 3'd0 ? ~sa :
             op_q == 3'd1 ? sa & sb :
             op_q == 3'd2 ? ~(sa & sb) :
             op_q == 3'd3 ? sa ^ sb :
             op_q == 3'd4 ? ~(sa ^ sb) :
             op_q == 3'd5 ? sa | sb :
             op_q == 3'd6 ? ~(sa | sb) : ~sb;
        // LSB slice first: each new slice enters at the top and earlier ones drift down
        p_next  = (p_q >> SLICE) | (WIDTH'(s) << (WIDTH - SLICE));
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        res_d   = res_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = BUSY;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    p_d     = '0;
                end
            end
            BUSY: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                p_d   = p_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    res_d   = p_next;
                    zero_d  = p_next == '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end
    assign busy   = state_q == BUSY;
    assign done   = state_q == DONE;
    assign result = res_q;
    assign zero   = zero_q;
endmodule

// File: tb/tb_lu_serial.sv
// tb_lu_serial: directed checks of lu_serial at 8x1 and 16x4 configurations.
module tb_lu_serial;
    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [2:0]  op8, op16;
    logic [7:0]  a8, b8, result8;
    logic [15:0] a16, b16, result16;
    logic        busy8, done8, zero8, busy16, done16, zero16;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  prev8 = 8'h00;
    always #5 clk = ~clk;
    lu_serial #(.WIDTH(8), .SLICE(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .zero(zero8)
    );
    lu_serial #(.WIDTH(16), .SLICE(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .zero(zero16)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp, input logic ez);
        @(negedge clk);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; op8 = ~o; a8 = ~x; b8 = ~y;
        for (int i = 0; i < 8; i++) begin
            check("busy8", busy8, 1);
            check("nodone8", done8, 0);
            check("hold8", result8, prev8);
            start8 = (i == 3);
            @(negedge clk);
        end
        start8 = 1'b0;
        check("done8", done8, 1);
        check("busyoff8", busy8, 0);
        check("res8", result8, exp);
        check("zero8", zero8, ez);
        prev8 = exp;
        @(negedge clk);
        check("pulse8", done8, 0);
        check("idle8", busy8, 0);
        check("held8", result8, exp);
    endtask
    initial begin
        int seen;
        logic [7:0] exps [8];
        exps = '{8'h0F, 8'hC0, 8'h3F, 8'h3C, 8'hC3, 8'hFC, 8'h03, 8'h33};
        rst = 1'b1; start8 = 0; start16 = 0;
        op8 = 0; a8 = 0; b8 = 0; op16 = 0; a16 = 0; b16 = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_res", result8, 8'h00);
        check("rst_zero", zero8, 1);
        check("rst_zero16", zero16, 1);
        rst = 1'b0;
        run8(3'b001, 8'hF0, 8'hCC, 8'hC0, 1'b0);
        for (int k = 0; k < 8; k++) run8(3'(k), 8'hF0, 8'hCC, exps[k], 1'b0);
        run8(3'b110, 8'hFF, 8'h00, 8'h00, 1'b1);
        run8(3'b000, 8'h00, 8'h00, 8'hFF, 1'b0);
        // back-to-back: start held through DONE
        @(negedge clk);
        op8 = 3'b001; a8 = 8'hF0; b8 = 8'hCC; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_done", done8, 1);
        check("b2b_res1", result8, 8'hC0);
        op8 = 3'b011; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_busy", busy8, 1);
        check("b2b_hold", result8, 8'hC0);
        repeat (7) @(negedge clk);
        check("b2b_busy_end", busy8, 1);
        @(negedge clk);
        check("b2b_done2", done8, 1);
        check("b2b_res2", result8, 8'h3C);
        @(negedge clk);
        // reset during the 4th BUSY cycle
        op8 = 3'b101; a8 = 8'hF0; b8 = 8'hCC; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        check("mid_rst_res", result8, 8'h00);
        check("mid_rst_zero", zero8, 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen++;
        end
        check("no_done_after_rst", seen, 0);
        // 16-bit, 4-bit slices
        op16 = 3'b011; a16 = 16'h1234; b16 = 16'hFFFF; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("busy16", busy16, 1);
            check("nodone16", done16, 0);
            @(negedge clk);
        end
        check("done16", done16, 1);
        check("res16", result16, 16'hEDCB);
        check("zero16", zero16, 0);
        @(negedge clk);
        check("pulse16", done16, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
